// File: rtl/regfile_operand_stage_if.sv
// Handshake and writeback bundle for the operand-fetch stage.
// master drives instructions, ALU ready and writeback; slave is the stage.
interface regfile_operand_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instruction;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instruction;
  logic [XLEN-1:0] out_rs1_value;
  logic [XLEN-1:0] out_rs2_value;
  logic            wb_enable;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output in_valid,
    output in_instruction,
    output out_ready,
    output wb_enable,
    output wb_rd,
    output wb_data,
    input  in_ready,
    input  out_valid,
    input  out_instruction,
    input  out_rs1_value,
    input  out_rs2_value
  );

  modport slave (
    input  in_valid,
    input  in_instruction,
    input  out_ready,
    input  wb_enable,
    input  wb_rd,
    input  wb_data,
    output in_ready,
    output out_valid,
    output out_instruction,
    output out_rs1_value,
    output out_rs2_value
  );
endinterface

// File: rtl/regfile_operand_stage.sv
// Operand fetch: 32x32 register file, write-first bypass,
// busy-bit scoreboard for RAW stalls, one-entry output register.
module regfile_operand_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic clock,
  input logic reset,
  regfile_operand_stage_if.slave bus
);
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [6:0]      opcode;
  logic            writes_rd;
  logic            uses_rs2;
  logic            wb_hit;
  logic            clr1;
  logic            clr2;
  logic            hazard;
  logic            ready;
  logic            accept;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  logic            out_valid_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;

  assign rs1    = bus.in_instruction[19:15];
  assign rs2    = bus.in_instruction[24:20];
  assign rd     = bus.in_instruction[11:7];
  assign opcode = bus.in_instruction[6:0];

  // Classify the opcode: which ones write rd and read rs2
  always_comb begin
    writes_rd = 1'b0;
    uses_rs2  = 1'b0;
    unique case (1'b1)
      (opcode == OP_R): begin
        writes_rd = 1'b1;
        uses_rs2  = 1'b1;
      end
      (opcode == OP_I): begin
        writes_rd = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign wb_hit = bus.wb_enable && (bus.wb_rd != 5'd0);
  assign clr1   = wb_hit && (bus.wb_rd == rs1);
  assign clr2   = wb_hit && (bus.wb_rd == rs2);

  // Operand reads: x0 is zero, same-cycle writeback wins
  always_comb begin
    rs1_value = regs[rs1];
    rs2_value = regs[rs2];
    if (clr1) rs1_value = bus.wb_data;
    if (clr2) rs2_value = bus.wb_data;
    if (rs1 == 5'd0) rs1_value = '0;
    if (rs2 == 5'd0) rs2_value = '0;
  end

  assign hazard = bus.in_valid &&
                  ((busy[rs1] && !clr1) ||
                   (uses_rs2 && busy[rs2] && !clr2));
  assign ready  = !reset && (!out_valid_q || bus.out_ready) && !hazard;
  assign accept = bus.in_valid && ready;

  // Scoreboard: writeback clears first, a new writer then sets
  always_comb begin
    busy_next = busy;
    if (bus.wb_enable) busy_next[bus.wb_rd] = 1'b0;
    if (accept && writes_rd && rd != 5'd0) busy_next[rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Busy bits register
  always_ff @(posedge clock) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  // Register file; writeback is dropped while in reset
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Output bundle: capture on accept, retire on consume, else hold
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      instr_q     <= bus.in_instruction;
      rs1_q       <= rs1_value;
      rs2_q       <= rs2_value;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready        = ready;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_instruction = instr_q;
  assign bus.out_rs1_value   = rs1_q;
  assign bus.out_rs2_value   = rs2_q;

  a_x0_never_busy: assert property (
    @(posedge clock) !busy[0]);

  a_hold_stable: assert property (
    @(posedge clock) disable iff (reset)
    (out_valid_q && !bus.out_ready) |=>
      (out_valid_q && $stable(instr_q) &&
       $stable(rs1_q) && $stable(rs2_q)));
endmodule

// File: tb/tb_regfile_operand_stage.sv
// Scoreboard bench for regfile_operand_stage.
// Directed scenarios followed by randomized traffic.
module tb_regfile_operand_stage;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
  } bundle_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  regfile_operand_stage_if #(.XLEN(XLEN)) bus();

  regfile_operand_stage #(.XLEN(XLEN), .NREGS(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  bundle_t     sb[$];
  int          pend[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_reg [32];
  bit          m_busy [32];
  bit          m_ov;
  logic [31:0] m_instr;
  bit          prev_rst;

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endfunction

  function automatic bit writes(logic [31:0] i);
    return (i[6:0] == OP_R) || (i[6:0] == OP_I);
  endfunction

  function automatic logic [31:0] rdv(int r, bit we, int wr,
                                      logic [31:0] wd);
    if (r == 0) return 32'd0;
    if (we && wr == r) return wd;
    return m_reg[r];
  endfunction

  task automatic step(bit v, logic [31:0] ins, bit ordy, bit we,
                      logic [4:0] wr, logic [31:0] wd, bit rst);
    int  rs1, rs2, rd;
    bit  o, haz, erdy, acc;
    bundle_t e;
    @(negedge clock);
    o = rst ? 1'b0 : ordy;
    reset              = rst;
    bus.in_valid       = v;
    bus.in_instruction = ins;
    bus.out_ready      = o;
    bus.wb_enable      = we;
    bus.wb_rd          = wr;
    bus.wb_data        = wd;
    #1;
    rs1 = int'(ins[19:15]);
    rs2 = int'(ins[24:20]);
    rd  = int'(ins[11:7]);
    haz = v && ((m_busy[rs1] && !(we && wr == rs1 && rs1 != 0)) ||
               (ins[6:0] == OP_R && m_busy[rs2] &&
                !(we && wr == rs2 && rs2 != 0)));
    erdy = !rst && (!m_ov || o) && !haz;
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, erdy});
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
    if (prev_rst) begin
      check("rst_instr", bus.out_instruction, 32'd0);
      check("rst_rs1", bus.out_rs1_value, 32'd0);
      check("rst_rs2", bus.out_rs2_value, 32'd0);
    end
    if (m_ov && !o && sb.size() > 0) begin
      check("hold_instr", bus.out_instruction, sb[0].instr);
      check("hold_rs1", bus.out_rs1_value, sb[0].a);
      check("hold_rs2", bus.out_rs2_value, sb[0].b);
    end
    acc = v && erdy;
    if (acc) begin
      e.instr = ins;
      e.a = rdv(rs1, we, int'(wr), wd);
      e.b = rdv(rs2, we, int'(wr), wd);
      sb.push_back(e);
    end
    if (m_ov && o && writes(m_instr) && m_instr[11:7] != 5'd0)
      pend.push_back(int'(m_instr[11:7]));
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = 32'd0;
        m_busy[i] = 1'b0;
      end
      m_ov = 1'b0;
      sb.delete();
      pend.delete();
    end else begin
      if (we && wr != 5'd0) m_reg[wr] = wd;
      if (we) m_busy[wr] = 1'b0;
      if (acc && writes(ins) && rd != 0) m_busy[rd] = 1'b1;
      if (acc) begin
        m_ov    = 1'b1;
        m_instr = ins;
      end else if (m_ov && o) begin
        m_ov = 1'b0;
      end
    end
    prev_rst = rst;
  endtask

  function automatic logic [31:0] gen();
    logic [31:0] i;
    i = $urandom;
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    i[11:7]  = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 4))
      0: i[6:0] = OP_R;
      1: i[6:0] = OP_I;
      2: i[6:0] = OP_R;
      3: i[6:0] = 7'b0000011;
      default: i[6:0] = 7'b1100011;
    endcase
    return i;
  endfunction

  // Monitor: retire bundles against the scoreboard
  initial begin : monitor
    bundle_t e;
    forever begin
      @(negedge clock);
      #2;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bundle: got %h expected none",
                   bus.out_instruction);
        end else begin
          e = sb.pop_front();
          check("out_instr", bus.out_instruction, e.instr);
          check("out_rs1", bus.out_rs1_value, e.a);
          check("out_rs2", bus.out_rs2_value, e.b);
        end
      end
    end
  end

  initial begin : driver
    bit          v, o, we, r;
    logic [4:0]  wr;
    bus.in_valid       = 1'b0;
    bus.in_instruction = '0;
    bus.out_ready      = 1'b0;
    bus.wb_enable      = 1'b0;
    bus.wb_rd          = '0;
    bus.wb_data        = '0;
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'd0;
      m_busy[i] = 1'b0;
    end
    m_ov     = 1'b0;
    m_instr  = '0;
    prev_rst = 1'b0;

    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0);
    // writeback then read x5
    step(0, 0, 1, 1, 5, 32'h0000_1234, 0);
    step(1, 32'h000280B3, 1, 0, 0, 0, 0);
    // same-cycle bypass of x6 on both operands
    step(1, 32'h00630133, 1, 1, 6, 32'hDEAD_BEEF, 0);
    // x1 busy, resolved by same-cycle writeback
    step(1, 32'h001081B3, 1, 1, 1, 32'h5, 0);
    // RAW on x3 stalls until writeback
    repeat (3) step(1, 32'h00118213, 1, 0, 0, 0, 0);
    step(1, 32'h00118213, 1, 1, 3, 32'h7, 0);
    // backpressure on the held bundle
    repeat (3) step(1, 32'h00500393, 0, 0, 0, 0, 0);
    step(1, 32'h00500393, 1, 0, 0, 0, 0);
    // x4 must be busy now
    step(1, 32'h00020593, 1, 0, 0, 0, 0);
    // x0 writes ignored, rd=x0 sets no busy
    step(0, 0, 1, 1, 0, 32'hFFFF_FFFF, 0);
    step(1, 32'h00000433, 1, 0, 0, 0, 0);
    step(1, 32'h00028013, 1, 0, 0, 0, 0);
    step(1, 32'h000004B3, 1, 0, 0, 0, 0);
    // reset with a bundle held, writeback ignored
    step(1, 32'h00028533, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 4, 32'h99, 1);
    step(1, 32'h00020593, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);

    // randomized traffic
    step(0, 0, 0, 0, 0, 0, 1);
    repeat (3000) begin
      v  = ($urandom_range(0, 3) != 0);
      o  = ($urandom_range(0, 3) != 0);
      we = 1'b0;
      wr = 5'd0;
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        we = 1'b1;
        wr = 5'(pend.pop_front());
      end else if ($urandom_range(0, 9) == 0) begin
        we = 1'b1;
        wr = 5'($urandom_range(0, 7));
      end
      r = ($urandom_range(0, 399) == 0);
      step(v, gen(), o, we, wr, $urandom, r);
    end
    repeat (4) step(0, 0, 1, 0, 0, 0, 0);
    check("drain", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_operand_stage.md
Name: regfile_operand_stage

Overview:
Operand-fetch stage directly upstream of the R/I-type ALU stage. It holds the 32x32 integer register file and accepts decoded-ready instructions over a valid/ready handshake. It reads rs1/rs2 (with write-first bypass) and presents instruction plus operand values to the ALU through a one-entry pipeline register. It takes ALU writeback (rd, rd_result) and uses a busy-register scoreboard to stall read-after-write hazards.

Parameters:
XLEN, 32, data width of registers and operands
NREGS, 32, number of architectural registers (index width fixed at 5 bits)

Ports:
clock  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept instruction this cycle
in_instruction  input  32  RV32I instruction word
out_valid  output  1  operand bundle valid toward ALU
out_ready  input  1  ALU accepts bundle this cycle
out_instruction  output  32  registered instruction word
out_rs1_value  output  XLEN  registered rs1 operand
out_rs2_value  output  XLEN  registered rs2 operand
wb_enable  input  1  writeback strobe from ALU result path
wb_rd  input  5  writeback destination register
wb_data  input  XLEN  writeback value (ALU rd_result)

Behaviour:
- Decode: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], opcode=instr[6:0].
- Writes-rd instruction: opcode 0110011 (R) or 0010011 (I). All other opcodes are non-writing and set no busy bit.
- uses_rs2: opcode 0110011 only. rs1 is always checked.
- Register file: x0 reads 0. Writes to x0 are ignored. On posedge, if wb_enable && wb_rd!=0, then reg[wb_rd]<=wb_data.
- Bypass: an operand read whose index equals wb_rd in a cycle with wb_enable && wb_rd!=0 returns wb_data, not the stale value.
- Scoreboard: busy[31:0]. busy[0] is constantly 0.
- Hazard = in_valid && ((busy[rs1] && !clr(rs1)) || (uses_rs2 && busy[rs2] && !clr(rs2))). clr(r) = wb_enable && wb_rd==r && r!=0, meaning same-cycle writeback resolves the hazard via bypass.
- in_ready = (!out_valid || out_ready) && !hazard. This is combinational.
- Accept = in_valid && in_ready. On accept, next cycle:
  - out_valid=1
  - out_instruction=in_instruction
  - out_rs1_value and out_rs2_value = bypassed read values at accept time. out_rs2_value is read even when !uses_rs2.
- Latency: accept in cycle N produces a bundle visible in cycle N+1. Back-to-back throughput is 1 per cycle when out_ready is held 1 and there are no hazards.
- If out_valid && out_ready && !accept, then out_valid<=0. Data outputs hold their last value.
- If out_valid && !out_ready, all out_* hold stable and in_ready=0.
- Operand values are captured once at accept. Later writebacks do not alter a held bundle.
- Busy update per cycle, in this order:
  - clear busy[wb_rd] if wb_enable.
  - then set busy[rd] if accept && writes-rd && rd!=0.
  - Simultaneous clear and set of the same index: set wins.
- Writeback to a register that is not busy still writes the register file. The clear is a no-op.
- Reset (sync):
  - out_valid=0, out_instruction=0, out_rs1_value=0, out_rs2_value=0.
  - busy=0 and all registers=0.
  - Any held bundle is dropped.
  - wb_enable during a reset cycle is ignored.
  - in_ready is evaluated from post-reset state only after reset deasserts. While reset=1, in_ready=0.
- No X propagation: all outputs are defined from the first cycle after reset.

Test Plan:
- Reset then idle: reset high 2 cycles -> out_valid=0, in_ready=1 after release, all outputs 0.
- Writeback + read: wb x5=0x0000_1234, then issue ADD x1,x5,x0 (0x000280B3) with out_ready=1 -> next cycle out_valid=1, out_rs1_value=0x1234, out_rs2_value=0.
- Bypass: wb x6=0xDEAD_BEEF in the same cycle as issuing ADD x2,x6,x6 -> bundle has both operands=0xDEADBEEF, no stall.
- RAW stall: issue ADD x3,x1,x1, then ADDI x4,x3,1 (0x00118213) with no wb -> in_ready=0 until wb x3=7, accepted that cycle with out_rs1_value=7; busy[4] is set afterward.
- Backpressure: out_ready=0 for 3 cycles with a bundle held -> out_* stable, in_ready=0; out_ready=1 -> bundle consumed, next instruction accepted the same cycle.
- x0 and reset mid-flight: wb x0=0xFFFF_FFFF then read x0 -> 0. Instruction with rd=x0 sets no busy bit. Reset while out_valid=1 -> out_valid=0 and busy cleared next cycle.
